// File: rtl/sd_cmd_phy_if.sv
// Host control/status and card command-line signals of sd_cmd_phy.
// master = host controller and card line model, slave = the command PHY.
interface sd_cmd_phy_if;
  logic         start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         busy;
  logic         done;
  logic [119:0] resp;
  logic         timeout_err;
  logic         crc_err;
  logic         index_err;
  logic         end_err;
  logic         cmd_en;
  logic         cmd_out;
  logic         cmd_in;

  modport master (
    output start, cmd_index, cmd_arg, resp_type, cmd_in,
    input  busy, done, resp, timeout_err, crc_err, index_err, end_err, cmd_en, cmd_out
  );

  modport slave (
    input  start, cmd_index, cmd_arg, resp_type, cmd_in,
    output busy, done, resp, timeout_err, crc_err, index_err, end_err, cmd_en, cmd_out
  );
endinterface

// File: rtl/sd_cmd_phy.sv
// Host-side SD command line engine: CRC7 command TX, response wait with timeout, response RX.
// Define SD_CMD_RESP_CRC_CHECK_EN to build the response CRC7 checker; otherwise crc_err is 0.
module sd_cmd_phy #(
  parameter int unsigned NCR_MAX = 64,
  parameter int unsigned NCC_GAP = 8
) (
  input logic         sd_clk,
  input logic         rst,
  sd_cmd_phy_if.slave bus
);
  typedef enum logic [2:0] {StIdle, StTx, StTurn, StWait, StRx, StDone, StGap} state_e;

  localparam logic [7:0] NcrLast = 8'(NCR_MAX - 1);
  localparam logic [7:0] GapLast = 8'(NCC_GAP - 1);

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  state_e       state_q;
  logic [7:0]   cnt_q;
  logic [46:0]  tx_sr_q;
  logic [119:0] pay_q;
  logic [5:0]   idx_q;
  logic [1:0]   type_q;
  logic         busy_q, done_q, cmd_en_q, cmd_out_q;
  logic         timeout_q, index_err_q, end_err_q;
  logic [119:0] resp_q;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
  logic [6:0]   crc_q, crc_rx_q;
  logic         crc_err_q;
`endif

  logic [39:0] tx_body;
  logic [6:0]  tx_crc;
  logic [47:0] tx_frame;

  always_comb begin
    tx_body = {2'b01, bus.cmd_index, bus.cmd_arg};
    tx_crc  = '0;
    for (int i = 39; i >= 0; i--) begin
      tx_crc = crc7_step(tx_crc, tx_body[i]);
    end
    tx_frame = {tx_body, tx_crc, 1'b1};
  end

  // cnt_q is shared: TX bits left, turnaround, NCR wait, RX bits left, gap.
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tx_sr_q     <= '0;
      pay_q       <= '0;
      idx_q       <= '0;
      type_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_en_q    <= 1'b0;
      cmd_out_q   <= 1'b1;
      timeout_q   <= 1'b0;
      index_err_q <= 1'b0;
      end_err_q   <= 1'b0;
      resp_q      <= '0;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
      crc_q       <= '0;
      crc_rx_q    <= '0;
      crc_err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q     <= StTx;
            busy_q      <= 1'b1;
            idx_q       <= bus.cmd_index;
            type_q      <= bus.resp_type;
            resp_q      <= '0;
            timeout_q   <= 1'b0;
            index_err_q <= 1'b0;
            end_err_q   <= 1'b0;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
            crc_err_q   <= 1'b0;
`endif
            cmd_en_q    <= 1'b1;
            cmd_out_q   <= tx_frame[47];
            tx_sr_q     <= tx_frame[46:0];
            cnt_q       <= 8'd47;
          end
        end
        StTx: begin
          if (cnt_q == 8'd0) begin
            cmd_en_q  <= 1'b0;
            cmd_out_q <= 1'b1;
            if (type_q == 2'b00) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StTurn;
              cnt_q   <= 8'd1;
            end
          end else begin
            cmd_out_q <= tx_sr_q[46];
            tx_sr_q   <= {tx_sr_q[45:0], 1'b1};
            cnt_q     <= cnt_q - 8'd1;
          end
        end
        StTurn: begin
          if (cnt_q == 8'd0) begin
            state_q <= StWait;
            cnt_q   <= 8'd1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StWait: begin
          if (!bus.cmd_in) begin
            state_q <= StRx;
            cnt_q   <= (type_q == 2'b10) ? 8'd135 : 8'd47;
            pay_q   <= '0;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
            crc_q   <= '0;
`endif
          end else if (cnt_q == NcrLast) begin
            state_q   <= StDone;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StRx: begin
          // Incoming bit has frame index cnt_q-1; payload keeps frame[127:8] / frame[47:8].
          if (cnt_q >= 8'd9) pay_q <= {pay_q[118:0], bus.cmd_in};
`ifdef SD_CMD_RESP_CRC_CHECK_EN
          if (cnt_q >= 8'd9 && cnt_q <= 8'd128) crc_q <= crc7_step(crc_q, bus.cmd_in);
          if (cnt_q >= 8'd2 && cnt_q <= 8'd8) crc_rx_q <= {crc_rx_q[5:0], bus.cmd_in};
`endif
          if (cnt_q == 8'd1) begin
            state_q   <= StDone;
            done_q    <= 1'b1;
            end_err_q <= !bus.cmd_in;
            resp_q    <= (type_q == 2'b10) ? pay_q : {88'd0, pay_q[31:0]};
            if (type_q == 2'b01) index_err_q <= (pay_q[37:32] != idx_q);
`ifdef SD_CMD_RESP_CRC_CHECK_EN
            if (type_q != 2'b11) crc_err_q <= (crc_q != crc_rx_q);
`endif
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StDone: begin
          state_q <= StGap;
          cnt_q   <= GapLast;
        end
        StGap: begin
          if (cnt_q == 8'd0) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.resp        = resp_q;
  assign bus.timeout_err = timeout_q;
  assign bus.index_err   = index_err_q;
  assign bus.end_err     = end_err_q;
  assign bus.cmd_en      = cmd_en_q;
  assign bus.cmd_out     = cmd_out_q;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
  assign bus.crc_err     = crc_err_q;
`else
  assign bus.crc_err     = 1'b0;
`endif
endmodule

// File: tb/tb_sd_cmd_phy.sv
// Directed bench for sd_cmd_phy: card line model, expected results queued per command.
module tb_sd_cmd_phy;
  localparam int unsigned NcrMax = 64;
  localparam int unsigned NccGap = 8;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
  localparam bit CrcEn = 1'b1;
`else
  localparam bit CrcEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sd_cmd_phy_if bus ();

  sd_cmd_phy #(.NCR_MAX(NcrMax), .NCC_GAP(NccGap)) dut (
    .sd_clk (clk),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct {
    int           lat;
    logic [119:0] resp;
    logic         to;
    logic         crc;
    logic         idx;
    logic         endb;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [6:0] crc7(input logic [135:0] d, input int n);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic exp_t mk(input int lat, input logic [119:0] resp, input logic to,
                              input logic crc, input logic idx, input logic endb);
    exp_t e;
    e.lat = lat; e.resp = resp; e.to = to; e.crc = crc; e.idx = idx; e.endb = endb;
    return e;
  endfunction

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command, capture the TX frame, play the reply, then check result and gap.
  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] rtype, input logic [47:0] exp_tx, input bit reply,
                         input logic [135:0] rframe, input int rlen, input int d,
                         input bit glitch, input exp_t e);
    logic [47:0] tx;
    logic        en_ok, en_gap, seen;
    int          lat, rs;
    exp_t        x;
    @(negedge clk);
    bus.cmd_index = idx;
    bus.cmd_arg   = arg;
    bus.resp_type = rtype;
    bus.start     = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    en_ok = 1'b1;
    for (int i = 0; i < 48; i++) begin
      tx[47-i] = bus.cmd_out;
      en_ok    = en_ok & bus.cmd_en;
      @(negedge clk);
    end
    check({tag, " tx_frame"}, tx, exp_tx);
    check({tag, " tx_en"}, en_ok, 1'b1);
    check({tag, " released"}, {bus.cmd_en, bus.cmd_out}, 2'b01);
    seen = 1'b0;
    lat  = 0;
    rs   = 3 + d;
    for (int o = 1; o <= 400 && !seen; o++) begin
      if (o > 1) @(negedge clk);
      if (bus.done) begin
        seen       = 1'b1;
        lat        = o;
        bus.cmd_in = 1'b1;
      end else if (reply && o >= rs && o < rs + rlen) begin
        bus.cmd_in = rframe[rlen-1-(o-rs)];
      end else if (glitch && (o == 1 || o == 2)) begin
        bus.cmd_in = 1'b0;
      end else begin
        bus.cmd_in = 1'b1;
      end
    end
    bus.cmd_in = 1'b1;
    check({tag, " done_seen"}, seen, 1'b1);
    if (sb.size() == 0) begin
      check({tag, " sb_nonempty"}, 1'b0, 1'b1);
      return;
    end
    x = sb.pop_front();
    if (!seen) return;
    check({tag, " latency"}, lat, x.lat);
    check({tag, " resp"}, bus.resp, x.resp);
    check({tag, " flags"}, {bus.timeout_err, bus.crc_err, bus.index_err, bus.end_err},
          {x.to, x.crc, x.idx, x.endb});
    check({tag, " busy_at_done"}, bus.busy, 1'b1);
    @(negedge clk);
    check({tag, " done_pulse"}, bus.done, 1'b0);
    bus.start = 1'b1;  // must be ignored during the gap
    @(negedge clk);
    bus.start = 1'b0;
    en_gap = bus.cmd_en;
    repeat (6) begin
      @(negedge clk);
      en_gap = en_gap | bus.cmd_en;
    end
    check({tag, " busy_gap_end"}, bus.busy, 1'b1);
    @(negedge clk);
    check({tag, " busy_idle"}, bus.busy, 1'b0);
    check({tag, " no_tx_in_gap"}, en_gap | bus.cmd_en, 1'b0);
    check({tag, " flags_held"}, {bus.timeout_err, bus.crc_err, bus.index_err, bus.end_err},
          {x.to, x.crc, x.idx, x.endb});
  endtask

  logic [119:0] cid;
  logic [135:0] r2_ok, r2_bad;
  logic [47:0]  r1_bad, r3;
  logic [39:0]  body;

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.cmd_index = '0;
    bus.cmd_arg   = '0;
    bus.resp_type = '0;
    bus.cmd_in    = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset line", {bus.cmd_en, bus.cmd_out}, 2'b01);
    check("reset busy_done", {bus.busy, bus.done}, 2'b00);
    check("reset flags", {bus.timeout_err, bus.crc_err, bus.index_err, bus.end_err}, 4'h0);
    check("reset resp", bus.resp, 120'd0);

    run_cmd("cmd0", 6'd0, 32'h0, 2'b00, 48'h400000000095, 1'b0, '0, 0, 0, 1'b0,
            mk(1, 120'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    run_cmd("cmd8", 6'd8, 32'h1AA, 2'b01, 48'h48000001AA87, 1'b1, 136'h08000001AA13, 48, 5,
            1'b1, mk(56, 120'h1AA, 1'b0, 1'b0, 1'b0, 1'b0));

    body = {2'b01, 6'd17, 32'h0000_0200};
    run_cmd("cmd17_to", 6'd17, 32'h0000_0200, 2'b01, {body, crc7({96'd0, body}, 40), 1'b1},
            1'b0, '0, 0, 0, 1'b0, mk(66, 120'd0, 1'b1, 1'b0, 1'b0, 1'b0));

    body   = {2'b00, 6'd5, 32'h1AA};
    r1_bad = {body, crc7({96'd0, body}, 40) ^ 7'h04, 1'b1};
    run_cmd("bad_r1", 6'd8, 32'h1AA, 2'b01, 48'h48000001AA87, 1'b1, {88'd0, r1_bad}, 48, 0,
            1'b0, mk(51, 120'h1AA, 1'b0, CrcEn, 1'b1, 1'b0));

    // Type 11 with garbage CRC/index field, start bit on the last NCR sample.
    r3   = 48'h3F00FF8000FF;
    body = {2'b01, 6'd41, 32'h40FF_8000};
    run_cmd("r3_late", 6'd41, 32'h40FF_8000, 2'b11, {body, crc7({96'd0, body}, 40), 1'b1},
            1'b1, {88'd0, r3}, 48, 62, 1'b0, mk(113, 120'h00FF8000, 1'b0, 1'b0, 1'b0, 1'b0));

    cid    = 120'h03_5344_5355_3136_4780_1234_5678_0145;
    r2_ok  = {8'h3F, cid, crc7({16'd0, cid}, 120), 1'b1};
    r2_bad = {r2_ok[135:1], 1'b0};
    run_cmd("cmd2_cid", 6'd2, 32'h0, 2'b10, 48'h4200000000_4D, 1'b1, r2_ok, 136, 3, 1'b0,
            mk(142, cid, 1'b0, 1'b0, 1'b0, 1'b0));
    run_cmd("cmd2_endbit", 6'd2, 32'h0, 2'b10, 48'h4200000000_4D, 1'b1, r2_bad, 136, 3, 1'b0,
            mk(142, cid, 1'b0, 1'b0, 1'b0, 1'b1));

    // Abort mid-TX with an asynchronous reset.
    @(negedge clk);
    bus.cmd_index = 6'd17;
    bus.cmd_arg   = 32'h1234_5678;
    bus.resp_type = 2'b01;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    check("abort tx_active", bus.cmd_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort line", {bus.cmd_en, bus.cmd_out}, 2'b01);
    check("abort busy", bus.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort no_done", {bus.done, bus.busy}, 2'b00);

    run_cmd("cmd0_after_rst", 6'd0, 32'h0, 2'b00, 48'h400000000095, 1'b0, '0, 0, 0, 1'b0,
            mk(1, 120'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
